// File: rtl/rs232in_fifo_if.sv
// Receive-byte FIFO interface: rs232in push side, peripheral pop side and status.
// The master drives the strobes and data; the slave (the FIFO) drives status and head byte.
interface rs232in_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  in_attention;
    logic [7:0]            in_data;
    logic                  rd;
    logic [7:0]            rd_data;
    logic [DEPTH_LOG2:0]   count;
    logic                  empty;
    logic                  full;
    logic                  overflow;
    logic                  clr_overflow;
    logic                  ser_nrts;

    modport master (
        output in_attention, in_data, rd, clr_overflow,
        input  rd_data, count, empty, full, overflow, ser_nrts
    );

    modport slave (
        input  in_attention, in_data, rd, clr_overflow,
        output rd_data, count, empty, full, overflow, ser_nrts
    );
endinterface

// File: rtl/rs232in_fifo.sv
// First-word-fall-through receive FIFO with count, sticky overflow and optional RTS.
// Define RS232IN_FIFO_RTS_EN to build the hysteretic RTS flow control; otherwise ser_nrts is 0.
module rs232in_fifo #(
    parameter int DEPTH_LOG2    = 4,
    parameter int RTS_THRESHOLD = 12,
    parameter int RTS_HYST      = 4
) (
    input  logic           clock,
    input  logic           rst_n,
    rs232in_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          empty_r;
    logic          full_r;
    logic          overflow_r;
    logic [7:0]    rd_data_r;

    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic [CW-1:0] count_nxt_s;
    logic [7:0]    rd_data_nxt_s;
    logic [PW-1:0] rd_ptr_inc_s;

    // Handshake decode: a pop frees the slot a full-FIFO push needs.
    always_comb begin
        push_s       = bus.in_attention && (!full_r || bus.rd);
        pop_s        = bus.rd && !empty_r;
        drop_s       = bus.in_attention && full_r && !bus.rd;
        rd_ptr_inc_s = rd_ptr_r + PW'(1);
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Head prefetch: when the queue holds a single byte, the new head can only be the incoming one.
    always_comb begin
        rd_data_nxt_s = rd_data_r;
        if (pop_s) begin
            if (count_r == CW'(1)) begin
                if (push_s) begin
                    rd_data_nxt_s = bus.in_data;
                end else begin
                    rd_data_nxt_s = rd_data_r;
                end
            end else begin
                rd_data_nxt_s = mem_r[rd_ptr_inc_s];
            end
        end else if (push_s && empty_r) begin
            rd_data_nxt_s = bus.in_data;
        end else begin
            rd_data_nxt_s = rd_data_r;
        end
    end

    // Byte storage, deliberately left without reset.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.in_data;
        end
    end

    // Pointers, occupancy, flags and registered head byte.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
            rd_data_r  <= 8'h00;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            count_r   <= count_nxt_s;
            empty_r   <= (count_nxt_s == CW'(0));
            full_r    <= (count_nxt_s == CW'(DEPTH));
            rd_data_r <= rd_data_nxt_s;
            // A fresh drop outranks a coincident clear.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (bus.clr_overflow) begin
                overflow_r <= 1'b0;
            end
        end
    end

`ifdef RS232IN_FIFO_RTS_EN
    logic nrts_r;

    // RTS hysteresis on the post-edge occupancy.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            nrts_r <= 1'b0;
        end else if (count_nxt_s >= CW'(RTS_THRESHOLD)) begin
            nrts_r <= 1'b1;
        end else if (count_nxt_s <= CW'(RTS_THRESHOLD - RTS_HYST)) begin
            nrts_r <= 1'b0;
        end
    end

    assign bus.ser_nrts = nrts_r;
`else
    assign bus.ser_nrts = 1'b0;
`endif

    assign bus.rd_data  = rd_data_r;
    assign bus.count    = count_r;
    assign bus.empty    = empty_r;
    assign bus.full     = full_r;
    assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_rs232in_fifo.sv
// Directed bench for rs232in_fifo: hand-computed expectations checked with immediate assertions.
module tb_rs232in_fifo;
    logic clock;
    logic rst_n;
    int   total;
    int   bad;
    logic exp_rts_on;

    rs232in_fifo_if #(.DEPTH_LOG2(4)) bus ();

    rs232in_fifo #(.DEPTH_LOG2(4), .RTS_THRESHOLD(12), .RTS_HYST(4)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        bus.in_attention = 1'b0;
        bus.rd           = 1'b0;
        bus.clr_overflow = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        bus.in_attention = 1'b1;
        bus.in_data      = b;
        tick();
    endtask

    task automatic pop();
        bus.rd = 1'b1;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
`ifdef RS232IN_FIFO_RTS_EN
        exp_rts_on = 1'b1;
`else
        exp_rts_on = 1'b0;
`endif
        bus.in_attention = 1'b0;
        bus.in_data      = 8'h00;
        bus.rd           = 1'b0;
        bus.clr_overflow = 1'b0;
        rst_n            = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_nrts", 32'(bus.ser_nrts), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'h00);
        rst_n = 1'b1;
        tick();
        pop();
        chk("rd_empty_count", 32'(bus.count), 32'd0);
        chk("rd_empty_empty", 32'(bus.empty), 32'd1);
        chk("rd_empty_ovf", 32'(bus.overflow), 32'd0);

        // Three bytes in, three out.
        push(8'h41);
        chk("fwft_head", 32'(bus.rd_data), 32'h41);
        chk("fwft_empty", 32'(bus.empty), 32'd0);
        push(8'h42);
        push(8'h43);
        chk("abc_count", 32'(bus.count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("abc_data", 32'(bus.rd_data), 32'h41 + 32'(i));
            pop();
            chk("abc_count_dn", 32'(bus.count), 32'(2 - i));
        end
        chk("abc_empty", 32'(bus.empty), 32'd1);

        // Fill to 16, seventeenth byte is dropped.
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_count", 32'(bus.count), 32'd16);
        chk("fill_ovf", 32'(bus.overflow), 32'd0);
        push(8'h10);
        chk("drop_ovf", 32'(bus.overflow), 32'd1);
        chk("drop_count", 32'(bus.count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("wrap_data", 32'(bus.rd_data), 32'(i));
            pop();
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_full", 32'(bus.full), 32'd0);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);

        bus.clr_overflow = 1'b1;
        tick();
        chk("clr_ovf", 32'(bus.overflow), 32'd0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        bus.in_attention = 1'b1;
        bus.in_data      = 8'hAA;
        bus.rd           = 1'b1;
        tick();
        chk("fullpp_count", 32'(bus.count), 32'd16);
        chk("fullpp_ovf", 32'(bus.overflow), 32'd0);
        chk("fullpp_head", 32'(bus.rd_data), 32'h21);

        // Drop coincident with clear: set wins.
        bus.in_attention = 1'b1;
        bus.in_data      = 8'hEE;
        bus.clr_overflow = 1'b1;
        tick();
        chk("clr_vs_drop", 32'(bus.overflow), 32'd1);
        bus.clr_overflow = 1'b1;
        tick();
        chk("clr_again", 32'(bus.overflow), 32'd0);

        for (int i = 0; i < 15; i++) begin
            chk("fullpp_data", 32'(bus.rd_data), 32'h21 + 32'(i));
            pop();
        end
        chk("fullpp_last", 32'(bus.rd_data), 32'hAA);
        pop();
        chk("fullpp_empty", 32'(bus.empty), 32'd1);

        // Empty FIFO with simultaneous push and pop.
        bus.in_attention = 1'b1;
        bus.in_data      = 8'h55;
        bus.rd           = 1'b1;
        tick();
        chk("emptypp_count", 32'(bus.count), 32'd1);
        chk("emptypp_head", 32'(bus.rd_data), 32'h55);
        pop();
        chk("emptypp_drain", 32'(bus.empty), 32'd1);

        // RTS hysteresis: on at 12, held through 9, off at 8.
        for (int i = 0; i < 11; i++) push(8'h60 + 8'(i));
        chk("rts_11", 32'(bus.ser_nrts), 32'd0);
        push(8'h6B);
        chk("rts_12", 32'(bus.ser_nrts), 32'(exp_rts_on));
        for (int i = 0; i < 3; i++) begin
            pop();
            chk("rts_hold", 32'(bus.ser_nrts), 32'(exp_rts_on));
        end
        chk("rts_count9", 32'(bus.count), 32'd9);
        pop();
        chk("rts_8", 32'(bus.ser_nrts), 32'd0);
        chk("rts_head", 32'(bus.rd_data), 32'h64);

        // Asynchronous reset mid-burst discards the queue.
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        chk("mid_rst_data", 32'(bus.rd_data), 32'h00);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        push(8'h77);
        chk("post_rst_head", 32'(bus.rd_data), 32'h77);
        chk("post_rst_count", 32'(bus.count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
